// File: rtl/psum_delay_reader.sv
// Read side of the partial-sum delay buffer: circular BRAM delay line with valid/ready and row-end flush.
// Optional macro PSUM_DELAY_ZERO_FILL_EN: emit forced-zero words during FILL (zero-initialised delay line).
//
// state | meaning
// IDLE  | nothing stored, waiting for first accept
// FILL  | 0 < o_count < RAM_DEPTH, priming the delay line
// RUN   | o_count == RAM_DEPTH, each accept returns the word from RAM_DEPTH accepts ago
// DRAIN | flush in progress, emitting stored words oldest-first
module psum_delay_reader #(
  parameter int RAM_WIDTH = 48,
  parameter int RAM_DEPTH = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [RAM_WIDTH-1:0]               i_data,
  input  logic                               i_flush,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [RAM_WIDTH-1:0]               o_data,
  output logic [$clog2(RAM_DEPTH+1)-1:0]     o_count,
  output logic                               o_busy
);

  localparam int CNT_W = $clog2(RAM_DEPTH + 1);
  localparam int PTR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
`ifdef PSUM_DELAY_ZERO_FILL_EN
  localparam bit ZERO_FILL = 1'b1;
`else
  localparam bit ZERO_FILL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t               state, state_n;
  logic [PTR_W-1:0]     wr_ptr, wr_n, rd_ptr, rd_n, rd_addr;
  logic [CNT_W-1:0]     cnt_n;
  logic [CNT_W:0]       wr_ext, cnt_ext, base_ext;
  logic                 accept, out_free, load, load_zero;
  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  assign o_ready  = i_ready & (state != DRAIN);
  assign o_busy   = (state == DRAIN);
  assign accept   = i_valid & o_ready;
  assign out_free = ~o_valid | i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      state   <= state_n;
      wr_ptr  <= wr_n;
      rd_ptr  <= rd_n;
      o_count <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    wr_n      = wr_ptr;
    rd_n      = rd_ptr;
    cnt_n     = o_count;
    load      = 1'b0;
    load_zero = 1'b0;
    rd_addr   = wr_ptr;
    wr_ext    = '0;
    cnt_ext   = '0;
    base_ext  = '0;
    if (accept)
      wr_n = (wr_ptr == PTR_W'(RAM_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_n     = CNT_W'(1);
          state_n   = FILL;
          load      = ZERO_FILL;
          load_zero = ZERO_FILL;
        end
      end
      FILL: begin
        if (accept) begin
          cnt_n     = o_count + 1'b1;
          load      = ZERO_FILL;
          load_zero = ZERO_FILL;
          if (cnt_n == CNT_W'(RAM_DEPTH))
            state_n = RUN;
        end
        if (i_flush)
          state_n = DRAIN;
      end
      RUN: begin
        load = accept;
        if (i_flush)
          state_n = DRAIN;
      end
      DRAIN: begin
        rd_addr = rd_ptr;
        if (out_free) begin
          if (o_count != '0) begin
            load  = 1'b1;
            cnt_n = o_count - 1'b1;
            rd_n  = (rd_ptr == PTR_W'(RAM_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Oldest stored word sits o_count slots behind the post-write pointer.
    if ((state == FILL || state == RUN) && i_flush) begin
      wr_ext   = (CNT_W+1)'(wr_n);
      cnt_ext  = (CNT_W+1)'(cnt_n);
      base_ext = (wr_ext >= cnt_ext) ? wr_ext - cnt_ext
                                     : wr_ext + (CNT_W+1)'(RAM_DEPTH) - cnt_ext;
      rd_n     = PTR_W'(base_ext);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= load_zero ? '0 : mem[rd_addr];
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Read of mem[wr_ptr] above sees the old word: read-before-write.
  always_ff @(posedge i_clk) begin
    if (accept)
      mem[wr_ptr] <= i_data;
  end

endmodule

// File: tb/tb_psum_delay_reader.sv
// Testbench for psum_delay_reader (RAM_DEPTH=4): vector table, corner sequences, random run vs. queue model.
module tb_psum_delay_reader;
  localparam int W = 48;
  localparam int D = 4;
`ifdef PSUM_DELAY_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
  logic [W-1:0] i_data = '0;
  logic         o_ready, o_valid, o_busy;
  logic [W-1:0] o_data;
  logic [2:0]   o_count;

  psum_delay_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_count(o_count), .o_busy(o_busy));

  always #5 i_clk = ~i_clk;

  int nvec = 0, nerr = 0;
  logic [W-1:0] stored[$];
  logic [W-1:0] expq[$];
  bit busy_m = 1'b0;

  typedef struct {
    logic v; logic [W-1:0] d; logic f; logic r;
    logic ev; logic [W-1:0] ed; int ec;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: stored words form a FIFO; overflow past D (or a flush) moves them to the output queue.
  task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    bit acc, had;
    i_valid = v; i_data = d; i_flush = f; i_ready = r;
    #1;
    chk("o_ready", W'(o_ready), W'(r && !busy_m));
    if (o_valid && r) begin
      if (expq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_output: got %0h expected none", o_data);
      end else begin
        chk("o_data", o_data, expq.pop_front());
      end
    end
    acc = v && r && !busy_m;
    had = stored.size() > 0;
    if (acc) begin
      stored.push_back(d);
      if (stored.size() > D) expq.push_back(stored.pop_front());
      else if (ZF) expq.push_back('0);
    end
    if (f && !busy_m && had) begin
      busy_m = 1'b1;
      while (stored.size() > 0) expq.push_back(stored.pop_front());
    end
    if (busy_m && expq.size() == 0) busy_m = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("o_busy", W'(o_busy), W'(busy_m));
    if (!busy_m) begin
      chk("o_count", W'(o_count), W'(stored.size()));
      chk("o_valid", W'(o_valid), W'(expq.size() != 0));
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    stored.delete(); expq.delete(); busy_m = 1'b0;
    chk("rst_o_valid", W'(o_valid), '0);
    chk("rst_o_data", o_data, '0);
    chk("rst_o_count", W'(o_count), '0);
    chk("rst_o_busy", W'(o_busy), '0);
  endtask

  task automatic drain_out(input string nm);
    int n = 0;
    while ((o_busy || expq.size() != 0) && n < 40) begin
      step(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    chk({nm, "_done"}, W'(n < 40), W'(1));
  endtask

  initial begin
    for (int k = 1; k <= 8; k++) begin
      tbl[k-1].v = 1'b1; tbl[k-1].d = W'(k); tbl[k-1].f = 1'b0; tbl[k-1].r = 1'b1;
      tbl[k-1].ev = (k > D) ? 1'b1 : ZF;
      tbl[k-1].ed = (k > D) ? W'(k - D) : '0;
      tbl[k-1].ec = (k > D) ? D : k;
    end
    tbl[8] = '{v: 1'b0, d: '0, f: 1'b0, r: 1'b1, ev: 1'b0, ed: '0, ec: D};

    @(negedge i_clk);
    do_reset();

    // 1: priming then delayed outputs
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      chk($sformatf("t1_valid[%0d]", i), W'(o_valid), W'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("t1_data[%0d]", i), o_data, tbl[i].ed);
      chk($sformatf("t1_count[%0d]", i), W'(o_count), W'(tbl[i].ec));
    end

    // 2: output hold under backpressure
    step(1'b1, W'(9), 1'b0, 1'b1);
    chk("t2_first", o_data, W'(5));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'(99), 1'b0, 1'b0);
      chk("t2_hold_valid", W'(o_valid), W'(1));
      chk("t2_hold_data", o_data, W'(5));
    end
    step(1'b1, W'(10), 1'b0, 1'b1);
    chk("t2_resume", o_data, W'(6));

    // 3: flush in RUN
    do_reset();
    for (int k = 1; k <= 6; k++) step(1'b1, W'(k), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("t3_busy", W'(o_busy), W'(1));
    chk("t3_count", W'(o_count), W'(4));
    drain_out("t3");
    chk("t3_count_end", W'(o_count), '0);
    chk("t3_ready_end", W'(o_ready), W'(1));

    // 4: flush together with an accept during FILL
    do_reset();
    step(1'b1, W'(1), 1'b0, 1'b1);
    step(1'b1, W'(2), 1'b0, 1'b1);
    step(1'b1, W'(3), 1'b1, 1'b1);
    chk("t4_count", W'(o_count), W'(3));
    drain_out("t4");
    chk("t4_count_end", W'(o_count), '0);

    // 5: reset mid-drain, no stale data afterwards
    do_reset();
    for (int k = 1; k <= 6; k++) step(1'b1, W'(k), 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    do_reset();
    for (int k = 9; k <= 13; k++) step(1'b1, W'(k), 1'b0, 1'b1);
    chk("t5_first", o_data, W'(9));

    // 6: pointer wraps twice
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, W'(100 + k), 1'b0, 1'b1);
      if (k > D) begin
        chk("t6_valid", W'(o_valid), W'(1));
        chk("t6_data", o_data, W'(100 + k - D));
      end
    end

    // random traffic against the queue model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] d;
      d = {16'($urandom), $urandom};
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    drain_out("rand");
    chk("rand_queue_empty", W'(expq.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
